// File: rtl/imem_loader.sv
// Boot-time loader: streams a length-prefixed little-endian image into instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 4096,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            wr_en,
    output logic [XLEN-1:0] wr_addr,
    output logic [31:0]     wr_data,
    output logic            core_hold,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLen  = 3'd1,
        StData = 3'd2,
        StDone = 3'd3,
        StErr  = 3'd4,
        StChk  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       len_q, len_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [XLEN-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              core_hold_q, core_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic        accept;
    logic [31:0] word_in;
    logic        last_word;
    state_e      end_state;

    assign word_in   = {in_data, shift_q};
    assign last_word = (32'(idx_q) == (len_q - 32'd1));
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign end_state = StChk;
`else
    assign end_state = StDone;
`endif

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            StLen, StData: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StChk:   in_ready = 1'b1;
`endif
            default: ;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        len_d       = len_q;
        idx_d       = idx_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        core_hold_d = core_hold_q;
        done_d      = done_q;
        error_d     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d     = StLen;
                    byte_cnt_d  = 2'd0;
                    idx_d       = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    core_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d       = 8'h00;
`endif
                end else if (state_q == StDone) begin
                    done_d      = 1'b1;
                    core_hold_d = 1'b0;
                end else if (state_q == StErr) begin
                    error_d     = 1'b1;
                    core_hold_d = 1'b1;
                end
            end

            StLen: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {in_data, shift_q[23:8]};
                    if (byte_cnt_q == 2'd3) begin
                        len_d = word_in;
                        if (word_in > 32'(DEPTH)) begin
                            state_d = StErr;
                        end else if (word_in == 32'd0) begin
                            state_d = end_state;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end

            StData: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {in_data, shift_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d      = chk_q ^ in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = XLEN'({idx_q, 2'b00});
                        wr_data_d = word_in;
                        idx_d     = idx_q + 1'b1;
                        if (last_word) begin
                            state_d = end_state;
                        end
                    end
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            StChk: begin
                if (accept) begin
                    state_d = (in_data == chk_q) ? StDone : StErr;
                end
            end
`endif

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            len_q       <= 32'd0;
            idx_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'd0;
            core_hold_q <= BOOT_HOLD;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign error   = error_q;
    // Hold asserts in the very cycle start is seen, even when booting released.
    assign core_hold = core_hold_q | ((state_q == StIdle) && start);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; a second instance covers BOOT_HOLD = 0.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, start_b, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, wr_en, core_hold, busy, done, error;
    logic [31:0] wr_addr, wr_data;
    logic        in_ready_b, wr_en_b, core_hold_b, busy_b, done_b, error_b;
    logic [31:0] wr_addr_b, wr_data_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  img [12];

    always #5 clk = ~clk;

    imem_loader #(.XLEN(32), .DEPTH(4096), .BOOT_HOLD(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error)
    );

    imem_loader #(.XLEN(32), .DEPTH(4096), .BOOT_HOLD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_data(8'h00), .in_valid(1'b0),
        .in_ready(in_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .core_hold(core_hold_b), .busy(busy_b), .done(done_b), .error(error_b)
    );

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 16) begin
            step();
            waited++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_img();
        for (int i = 0; i < 12; i++) send(img[i]);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < wa.size()) ? wa[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] qd(input int i);
        return (i < wd.size()) ? wd[i] : 32'hxxxxxxxx;
    endfunction

    initial begin
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rst = 1'b1; start = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_core_hold", {31'd0, core_hold}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hold_b", {31'd0, core_hold_b}, 32'd0);
        start_b = 1'b1;
        #1;
        check("start_hold_b", {31'd0, core_hold_b}, 32'd1);
        step();
        start_b = 1'b0;
        check("after_start_hold_b", {31'd0, core_hold_b}, 32'd1);

        // Back-to-back image
        wa.delete(); wd.delete();
        pulse_start();
        check("len_in_ready", {31'd0, in_ready}, 32'd1);
        check("len_busy", {31'd0, busy}, 32'd1);
        send_img();
        check("b2b_wr_en", {31'd0, wr_en}, 32'd1);
        check("b2b_wr_addr", wr_addr, 32'h4);
        check("b2b_wr_data", wr_data, 32'hDEADBEEF);
        check("b2b_done_early", {31'd0, done}, 32'd0);
        step();
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_core_hold", {31'd0, core_hold}, 32'd0);
        check("b2b_wr_en_off", {31'd0, wr_en}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd0);
        check("b2b_nwr", wa.size(), 32'd2);
        check("b2b_a0", qa(0), 32'h0);
        check("b2b_d0", qd(0), 32'h00000013);
        check("b2b_a1", qa(1), 32'h4);
        check("b2b_d1", qd(1), 32'hDEADBEEF);

        // Same image, valid every other cycle
        wa.delete(); wd.delete();
        pulse_start();
        check("tog_done_clr", {31'd0, done}, 32'd0);
        check("tog_hold", {31'd0, core_hold}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            in_data = img[i];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            in_data = 8'hA5;
            step();
        end
        check("tog_done", {31'd0, done}, 32'd1);
        check("tog_nwr", wa.size(), 32'd2);
        check("tog_d0", qd(0), 32'h00000013);
        check("tog_a1", qa(1), 32'h4);
        check("tog_d1", qd(1), 32'hDEADBEEF);

        // Oversize header
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h01); send(8'h10); send(8'h00); send(8'h00);
        in_valid = 1'b0;
        check("err_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("err_error", {31'd0, error}, 32'd1);
        check("err_hold", {31'd0, core_hold}, 32'd1);
        check("err_done", {31'd0, done}, 32'd0);
        in_valid = 1'b1; in_data = 8'h00;
        step(); step();
        in_valid = 1'b0;
        check("err_in_ready2", {31'd0, in_ready}, 32'd0);
        check("err_nwr", wa.size(), 32'd0);
        pulse_start();
        check("err_clr", {31'd0, error}, 32'd0);
        send_img();
        step();
        check("rec_done", {31'd0, done}, 32'd1);
        check("rec_error", {31'd0, error}, 32'd0);
        check("rec_nwr", wa.size(), 32'd2);

        // Zero-length image
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'h00);
        in_valid = 1'b0;
        step();
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_nwr", wa.size(), 32'd0);

        // start during DATA is ignored
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send(img[i]);
        start = 1'b1;
        send(img[5]);
        start = 1'b0;
        check("ign_busy", {31'd0, busy}, 32'd1);
        for (int i = 6; i < 12; i++) send(img[i]);
        in_valid = 1'b0;
        step();
        check("ign_done", {31'd0, done}, 32'd1);
        check("ign_nwr", wa.size(), 32'd2);
        check("ign_d1", qd(1), 32'hDEADBEEF);

        // Reset after 5 of 8 payload bytes
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 0; i < 9; i++) send(img[i]);
        in_valid = 1'b0;
        check("mid_nwr", wa.size(), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_wr_en", {31'd0, wr_en}, 32'd0);
        check("mid_wr_addr", wr_addr, 32'h0);
        check("mid_wr_data", wr_data, 32'h0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_error", {31'd0, error}, 32'd0);
        check("mid_hold", {31'd0, core_hold}, 32'd1);
        step();
        check("mid_idle_ready", {31'd0, in_ready}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good checksum
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h44);
        in_valid = 1'b0;
        step();
        check("ck_done", {31'd0, done}, 32'd1);
        check("ck_d0", qd(0), 32'h44332211);
        // Bad checksum
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h45);
        in_valid = 1'b0;
        step();
        check("ckbad_error", {31'd0, error}, 32'd1);
        check("ckbad_done", {31'd0, done}, 32'd0);
        check("ckbad_hold", {31'd0, core_hold}, 32'd1);
        check("ckbad_nwr", wa.size(), 32'd1);
        check("ckbad_a0", qa(0), 32'h0);
        check("ckbad_d0", qd(0), 32'h44332211);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes a program image into the instruction memory's write port from a byte stream, e.g. a UART receiver or testbench driver. It assembles little-endian words, issues one word write per four payload bytes at byte addresses starting from 0, and holds the core until the image is complete. It sits between the host link and the instruction memory, and drives the core's hold/reset request.

## Interface
- XLEN, 32, width of the write address (byte address)
- DEPTH, 4096, instruction memory capacity in 32-bit words; maximum accepted word count
- BOOT_HOLD, 1, reset value of core_hold (1 = core held from reset until first load completes)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a load
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  instruction memory write strobe, one cycle per word
- wr_addr  output  XLEN  byte address of the word being written (word index << 2)
- wr_data  output  32  assembled word
- core_hold  output  1  keep core in reset/stalled
- busy  output  1  load in progress (LEN or DATA state)
- done  output  1  last load completed successfully (sticky until next start)
- error  output  1  last load failed (sticky until next start)

## Operation
- Handshake: a byte transfers on a cycle with in_valid && in_ready. in_ready = 1 only in LEN, DATA and CHK; no transfer when in_valid is low.
- Image format: 4-byte little-endian word count N, then N*4 payload bytes; each group of 4 bytes is little-endian (first byte -> wr_data[7:0]).
- States:
  - IDLE: wait for start -> LEN; clear done/error; core_hold = 1.
  - LEN: collect 4 bytes into N. After the 4th byte: N > DEPTH -> ERR; N == 0 -> DONE (or CHK when checksum is enabled); else -> DATA.
  - DATA: assemble bytes. On the 4th byte of a word, register the write and advance the word index. After word N-1 -> DONE (or CHK).
  - DONE: core_hold = 0, done = 1. start -> LEN.
  - ERR: core_hold = 1, error = 1, in_ready = 0. start -> LEN.
- start is ignored in LEN, DATA and CHK.
- Byte counter is 2 bits and wraps 3 -> 0. The word index is wide enough for DEPTH and wr_addr = index << 2, zero-extended to XLEN.
- The same index is never written twice within one load. Words at or beyond N are not touched.

## Timing
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, error 0, core_hold = BOOT_HOLD.
- With BOOT_HOLD = 1, IDLE after reset holds the core. With BOOT_HOLD = 0, core_hold is 0 in IDLE after reset and 1 from the start cycle onward.
- State changes one cycle after start is sampled, so in_ready rises the cycle after start.
- wr_en pulses exactly one cycle, the cycle after the 4th byte of a word is accepted. wr_addr and wr_data are valid that cycle and hold until the next write.
- in_ready stays high during the wr_en cycle; the loader never back-pressures inside a load. Peak throughput is one byte per cycle.
- done/core_hold change the cycle after the last write strobe (wr_en and the DONE transition happen in the same cycle).
- rst mid-load aborts immediately and restores reset values. Words already written remain in memory.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the payload (or after the header when N == 0), state CHK accepts one byte.
  - If that byte equals the XOR of all payload bytes -> DONE; otherwise -> ERR. Words already written are not rolled back.
- IMEM_LOADER_CHECKSUM_EN undefined: no CHK state and no checksum logic; payload end goes directly to DONE.

## Test plan
- Reset (BOOT_HOLD=1) -> core_hold=1, in_ready=0, wr_en=0, done=0, error=0. Repeat with BOOT_HOLD=0 -> core_hold=0.
- start, then bytes 02 00 00 00, 13 00 00 00, EF BE AD DE, back-to-back:
  - writes (0x0, 0x00000013) then (0x4, 0xDEADBEEF), one wr_en cycle each.
  - done=1 and core_hold=0 one cycle after the last wr_en.
- Same image with in_valid toggling every other cycle -> identical writes; no extra wr_en; bytes accepted only when valid.
- Header 01 10 00 00 (N=4097 > DEPTH) -> ERR: error=1, in_ready=0, no wr_en. A subsequent start with a valid image -> done=1, error=0.
- Header 00 00 00 00 -> DONE with zero writes. A start pulse during DATA is ignored. rst after 5 of 8 payload bytes -> one write issued, all outputs return to reset values.
- With IMEM_LOADER_CHECKSUM_EN:
  - N=1, payload 11 22 33 44, checksum 44 -> done=1.
  - Same image with checksum 45 -> error=1, core_hold=1; the write to 0x0 (0x44332211) still occurred.
